// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-mode SPI master.
package spi_pkg;

  // Controller states, from idle through an optional deselect gap to the word transfer.
  typedef enum logic [2:0] {
    IDLE,
    DESEL,
    SETUP,
    XFER,
    DONE
  } spi_state_t;

  // SPI mode as captured at accept: clock idle level and sampling phase.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of the chip-select index; a single device still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Tick generator: one tick every CLK_DIV clk cycles while enabled; restart zeroes the phase.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CW'(CLK_DIV - 1));

  // Count up to CLK_DIV-1 and wrap; hold at zero when idle or restarted.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: CPOL/CPHA modes, multiple chip selects, optional CS hold.
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first input for LSB-first words.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_CS   = 2,
  parameter  int CLK_DIV  = 4,
  localparam int CS_SEL_W = sel_width(NUM_CS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   din,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                hold_cs,
`ifdef SPI_LSB_FIRST_EN
  input  logic                lsb_first,
`endif
  output logic [DATA_W-1:0]   dout,
  output logic                done,
  output logic                busy,
  input  logic                sdi,
  output logic                sdo,
  output logic                sclk,
  output logic [NUM_CS-1:0]   cs_n
);

  localparam int EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_t          state_q, state_d;
  spi_mode_t           mode_q, mode_d;
  logic                lsb_q, lsb_d;
  logic                hold_q, hold_d;
  logic                held_q, held_d;
  logic [CS_SEL_W-1:0] sel_q, sel_d;
  logic [CS_SEL_W-1:0] held_sel_q, held_sel_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic                lsb_in;
  logic [CS_SEL_W-1:0] sel_in;
  logic                accept;
  logic                tick;
  logic                din_first, tx_bit;
  logic [DATA_W-1:0]   din_shift, tx_shift, rx_shift;
  logic                sample_edge;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Out-of-range selects fall back to device 0.
  assign sel_in = (int'(cs_sel) >= NUM_CS) ? '0 : cs_sel;
  assign accept = (state_q == IDLE) && start;

  assign din_first   = lsb_in ? din[0] : din[DATA_W-1];
  assign din_shift   = lsb_in ? (din >> 1) : (din << 1);
  assign tx_bit      = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
  assign tx_shift    = lsb_q ? (tx_q >> 1) : (tx_q << 1);
  assign rx_shift    = lsb_q ? {sdi, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], sdi};
  assign sample_edge = (~edge_q[0]) ^ mode_q.cpha;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .enable (state_q != IDLE),
    .tick   (tick)
  );

  function automatic logic [NUM_CS-1:0] cs_low_mask(input logic [CS_SEL_W-1:0] s);
    logic [NUM_CS-1:0] m;
    m    = '1;
    m[s] = 1'b0;
    return m;
  endfunction

  // Next-state and datapath: accept, optional deselect gap, setup, edge sequencing, completion.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lsb_d      = lsb_q;
    hold_d     = hold_q;
    held_d     = held_q;
    sel_d      = sel_q;
    held_sel_d = held_sel_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dout_d     = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          mode_d.cpha = cpha;
          lsb_d       = lsb_in;
          hold_d      = hold_cs;
          sel_d       = sel_in;
          tx_d        = din;
          edge_d      = '0;
          if (held_q && (held_sel_q == sel_in)) begin
            // Held CS on the same device: keep the old clock polarity and go straight to edges.
            state_d = XFER;
            if (!cpha) begin
              sdo_d = din_first;
              tx_d  = din_shift;
            end
          end else if (held_q) begin
            state_d     = DESEL;
            mode_d.cpol = cpol;
            held_d      = 1'b0;
            cs_n_d      = '1;
          end else begin
            state_d     = SETUP;
            mode_d.cpol = cpol;
            sclk_d      = cpol;
            cs_n_d      = cs_low_mask(sel_in);
            if (!cpha) begin
              sdo_d = din_first;
              tx_d  = din_shift;
            end
          end
        end
      end
      DESEL: begin
        if (tick) begin
          state_d = SETUP;
          sclk_d  = mode_q.cpol;
          cs_n_d  = cs_low_mask(sel_q);
          if (!mode_q.cpha) begin
            sdo_d = tx_bit;
            tx_d  = tx_shift;
          end
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          if (sample_edge) begin
            rx_d = rx_shift;
          end else if (edge_q != LAST_EDGE) begin
            sdo_d = tx_bit;
            tx_d  = tx_shift;
          end
          if (edge_q == LAST_EDGE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dout_d  = rx_q;
        if (hold_q) begin
          held_d     = 1'b1;
          held_sel_d = sel_q;
        end else begin
          held_d = 1'b0;
          cs_n_d = '1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register bank with synchronous reset; reset aborts any transfer and releases CS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      lsb_q      <= 1'b0;
      hold_q     <= 1'b0;
      held_q     <= 1'b0;
      sel_q      <= '0;
      held_sel_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lsb_q      <= lsb_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      sel_q      <= sel_d;
      held_sel_q <= held_sel_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dout_q     <= dout_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;
  assign busy = busy_q;
  assign sdo  = sdo_q;
  assign sclk = sclk_q;
  assign cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi with a behavioural SPI slave and transfer model.
module tb_spi_master_multi;

  localparam int DATA_W   = 8;
  localparam int NUM_CS   = 3;
  localparam int CLK_DIV  = 2;
  localparam int CS_SEL_W = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [DATA_W-1:0]   din;
  logic [CS_SEL_W-1:0] cs_sel;
  logic                cpol;
  logic                cpha;
  logic                hold_cs;
  logic [DATA_W-1:0]   dout;
  logic                done;
  logic                busy;
  logic                sdi;
  logic                sdo;
  logic                sclk;
  logic [NUM_CS-1:0]   cs_n;
`ifdef SPI_LSB_FIRST_EN
  logic                lsb_first;
`endif

  spi_master_multi #(
    .DATA_W (DATA_W),
    .NUM_CS (NUM_CS),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (din),
    .cs_sel   (cs_sel),
    .cpol     (cpol),
    .cpha     (cpha),
    .hold_cs  (hold_cs),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .dout     (dout),
    .done     (done),
    .busy     (busy),
    .sdi      (sdi),
    .sdo      (sdo),
    .sclk     (sclk),
    .cs_n     (cs_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Slave model state.
  logic [DATA_W-1:0] sw_word;
  logic              sl_cpha;
  logic              sl_lsb;
  int                sl_sel;
  int                edge_n;
  int                idx;
  logic [DATA_W-1:0] cap;
  int                ncap;
  logic              first_bit;
  logic              prev_sclk;
  logic              prev_cs_low;
  int                cs_viol;
  int                gap_cnt;
  int                done_seen;

  // Transfer model state: which device is held and with what clock polarity.
  logic              m_held = 1'b0;
  int                m_held_sel = 0;
  logic              m_cpol = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic slaveBit(input int i);
    if (i >= DATA_W) return 1'b0;
    return sl_lsb ? sw_word[i] : sw_word[DATA_W-1-i];
  endfunction

  // One clock: advance to the falling edge, then play the slave and the bus monitors.
  task automatic stepCycle();
    logic cs_low;
    int   zeros;
    @(negedge clk);
    cyc++;
    cs_low = (cs_n[sl_sel] == 1'b0);
    if ((sclk !== prev_sclk) && cs_low && prev_cs_low) begin
      edge_n++;
      if ((edge_n % 2 == 1) ^ sl_cpha) begin
        if (ncap == 0) first_bit = sdo;
        cap = sl_lsb ? {sdo, cap[DATA_W-1:1]} : {cap[DATA_W-2:0], sdo};
        ncap++;
      end else if (!sl_cpha) begin
        idx++;
        sdi = slaveBit(idx);
      end else begin
        sdi = slaveBit(idx);
        idx++;
      end
    end
    prev_sclk   = sclk;
    prev_cs_low = cs_low;
    zeros = 0;
    for (int i = 0; i < NUM_CS; i++) if (cs_n[i] == 1'b0) zeros++;
    if (zeros > 1) cs_viol++;
    if (busy && (cs_n == '1)) gap_cnt++;
    if (done) done_seen++;
  endtask

  // One complete transfer checked against the model's latency, data, framing and CS rules.
  task automatic applyStimulus(input string tag, input logic [DATA_W-1:0] d, input int s,
                               input logic pl, input logic ph, input logic hc, input logic lf,
                               input logic [DATA_W-1:0] sw, input bit glitch);
    int   es, a, lat, exp_lat;
    logic match, mism, exp_cpol;
    logic [NUM_CS-1:0] exp_cs;
    es       = (s >= NUM_CS) ? 0 : s;
    match    = m_held && (m_held_sel == es);
    mism     = m_held && !match;
    exp_lat  = 2 * DATA_W * CLK_DIV + 1 + (match ? 0 : CLK_DIV) + (mism ? CLK_DIV : 0);
    exp_cpol = match ? m_cpol : pl;
    din      = d;
    cs_sel   = CS_SEL_W'(s);
    cpol     = pl;
    cpha     = ph;
    hold_cs  = hc;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = lf;
    sl_lsb    = lf;
`else
    sl_lsb    = 1'b0;
`endif
    start       = 1'b1;
    sw_word     = sw;
    sl_cpha     = ph;
    sl_sel      = es;
    edge_n      = 0;
    idx         = 0;
    cap         = '0;
    ncap        = 0;
    first_bit   = 1'bx;
    gap_cnt     = 0;
    done_seen   = 0;
    sdi         = ph ? 1'b0 : slaveBit(0);
    prev_cs_low = (cs_n[es] == 1'b0);
    prev_sclk   = sclk;
    stepCycle();
    start = 1'b0;
    a = cyc;
    checkOutput({tag, "_busy_rise"}, 32'(busy), 32'd1);
    if (glitch) begin
      repeat (5) stepCycle();
      start  = 1'b1;
      din    = ~d;
      cpol   = ~pl;
      cpha   = ~ph;
      cs_sel = CS_SEL_W'((es + 1) % NUM_CS);
      stepCycle();
      start  = 1'b0;
    end
    while ((done_seen == 0) && (cyc - a < 200)) stepCycle();
    if (done_seen == 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    lat = cyc - a;
    exp_cs = '1;
    if (hc) exp_cs[es] = 1'b0;
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_dout"}, 32'(dout), 32'(sw));
    checkOutput({tag, "_sdo_word"}, 32'(cap), 32'(d));
    checkOutput({tag, "_bits"}, 32'(ncap), 32'(DATA_W));
    checkOutput({tag, "_edges"}, 32'(edge_n), 32'(2 * DATA_W));
    checkOutput({tag, "_first_bit"}, 32'(first_bit), 32'(sl_lsb ? d[0] : d[DATA_W-1]));
    checkOutput({tag, "_sclk_idle"}, 32'(sclk), 32'(exp_cpol));
    checkOutput({tag, "_busy_fall"}, 32'(busy), 32'd0);
    checkOutput({tag, "_cs_gap"}, 32'(gap_cnt), 32'(mism ? CLK_DIV : 0));
    checkOutput({tag, "_cs_after"}, 32'(cs_n), 32'(exp_cs));
    m_held     = hc;
    m_held_sel = es;
    if (!match) m_cpol = pl;
    stepCycle();
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    din         = '0;
    cs_sel      = '0;
    cpol        = 1'b0;
    cpha        = 1'b0;
    hold_cs     = 1'b0;
    sdi         = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    lsb_first   = 1'b0;
`endif
    sw_word     = '0;
    sl_cpha     = 1'b0;
    sl_lsb      = 1'b0;
    sl_sel      = 0;
    edge_n      = 0;
    idx         = 0;
    cap         = '0;
    ncap        = 0;
    first_bit   = 1'b0;
    prev_sclk   = 1'b0;
    prev_cs_low = 1'b0;
    cs_viol     = 0;
    gap_cnt     = 0;
    done_seen   = 0;
    repeat (3) stepCycle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_sdo", 32'(sdo), 32'd0);
    checkOutput("rst_sclk", 32'(sclk), 32'd0);
    checkOutput("rst_cs_n", 32'(cs_n), 32'h7);
    reset = 1'b0;
    stepCycle();

    applyStimulus("mode0_a5", 8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
    for (int m = 1; m < 4; m++) begin
      applyStimulus($sformatf("mode%0d", m), 8'h81, 1, m[1], m[0], 1'b0, 1'b0, 8'h81, 1'b0);
    end

    applyStimulus("hold_op", 8'h03, 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
    applyStimulus("hold_w1", 8'h12, 2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
    applyStimulus("hold_w2", 8'h34, 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
    applyStimulus("hold_w3", 8'h56, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0);

    applyStimulus("desel_a", 8'h9F, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    applyStimulus("desel_b", 8'h6E, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);

    applyStimulus("range_a", 8'hE7, 3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0);
    applyStimulus("range_b", 8'h18, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b0);

    applyStimulus("busy_ign", 8'hC9, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h37, 1'b1);

`ifdef SPI_LSB_FIRST_EN
    applyStimulus("lsb_first", 8'h01, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      applyStimulus($sformatf("rand%0d", n), DATA_W'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
                    DATA_W'($urandom), ($urandom_range(0, 7) == 0));
    end
    applyStimulus("release", 8'h5C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0);

    // Reset in the middle of a transfer with cpol=1 so the sclk reset value is visible.
    din       = 8'hF0;
    cs_sel    = 2'd1;
    cpol      = 1'b1;
    cpha      = 1'b0;
    hold_cs   = 1'b1;
    start     = 1'b1;
    done_seen = 0;
    stepCycle();
    start = 1'b0;
    repeat (12) stepCycle();
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    stepCycle();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cs_n", 32'(cs_n), 32'h7);
    checkOutput("abort_sclk", 32'(sclk), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    reset  = 1'b0;
    m_held = 1'b0;
    repeat (40) stepCycle();
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);
    checkOutput("abort_idle", 32'(busy), 32'd0);

    applyStimulus("post_abort", 8'h3A, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hD4, 1'b0);

    checkOutput("cs_onehot", 32'(cs_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
